param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised register file that generalises the fixed 8-input, 32-bit read selector into a storage block.
- Parameters set the entry count and data width; there are two independent registered read ports.
- One synchronous write port has optional write-to-read forwarding. A synchronous bulk clear and an optional hardwired zero entry are included.
- Sits between datapath units (shifter, counter, ALU) as the shared operand store.

Parameters:
- DATA_WIDTH, 32, bits per entry and per read/write data port.
- ADDR_WIDTH, 3, address bits; entry count DEPTH = 2**ADDR_WIDTH (default 8).
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new write data; 0 = it returns the old contents.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded; 0 = entry 0 is ordinary storage.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of all entries.
- we  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- re0  input  1  read request, port 0.
- rd_addr0  input  ADDR_WIDTH  read address, port 0.
- rd_data0  output  DATA_WIDTH  registered read data, port 0.
- rd_valid0  output  1  rd_data0 holds the result of a request made on the previous edge.
- re1, rd_addr1, rd_data1, rd_valid1: identical to port 0, for port 1.

Behaviour:
- Reset (async, active-high): all DEPTH entries, rd_data0/1 and rd_valid0/1 go to 0 immediately. They stay 0 while reset is high. The first edge after deassertion operates normally.
- Write: on a rising edge with we=1 and clear=0, entry[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Clear: on a rising edge with clear=1, all entries become 0 and any simultaneous write is ignored. Priority is reset > clear > write.
- Read latency is 1 cycle. On a rising edge with reX=1, rd_dataX <= selected value and rd_validX <= 1.
  - On an edge with reX=0, rd_validX <= 0 and rd_dataX holds its previous value.
- Selected value, in priority order:
  - ZERO_REG=1 and rd_addrX=0: returns 0.
  - BYPASS=1, we=1, clear=0, wr_addr=rd_addrX, and the write is not dropped by ZERO_REG: returns wr_data.
  - Otherwise: returns entry[rd_addrX] as stored before this edge.
- A read in the same cycle as clear returns the pre-clear contents. The clear applies to storage only; bypass does not apply in that cycle.
- Both ports may read the same or different addresses in the same cycle with no conflict. Each port applies the bypass rule independently.
- Addresses cover the full range 0..DEPTH-1, so there are no out-of-range cases and no wrap.
- Only entries and read registers are sequential. There is no combinational path from any input to rd_data.
- Storage is an array of DEPTH x DATA_WIDTH registers. Read selection is a generic DEPTH-to-1 mux per port, not a hand-enumerated case.

Test Plan:
- Reset: assert reset mid-run after writing 32'hDEADBEEF to entry 3.
  - Required: rd_data0/1=0 and rd_valid0/1=0 immediately.
  - Required after release: a read of entry 3 returns 0 one cycle later with rd_valid0=1.
- Write then read all entries: write entry[i] = 32'h1000_0000 + i for i = 0..7. Then read port0 addr i and port1 addr 7-i on the same edges.
  - Required: each value appears 1 cycle after its request with valid=1.
  - Required: with re=0, valid drops to 0 and data holds.
- Bypass: with entry 5 = 32'h0000_00AA, in one cycle drive we=1, wr_addr=5, wr_data=32'h0000_0055, re0=1, rd_addr0=5.
  - Required with BYPASS=1: rd_data0=32'h55 next cycle.
  - Required with BYPASS=0: rd_data0=32'hAA, then 32'h55 on the following read.
- Clear vs write: set clear=1, we=1, wr_addr=2, wr_data=32'h1234, re1=1, rd_addr1=2, with entry 2 = 32'h77.
  - Required: rd_data1=32'h77 next cycle; a later read of entry 2 returns 0.
- ZERO_REG=1: write 32'hFFFF_FFFF to entry 0 while reading entry 0 on both ports in the same cycle, and on the next cycle.
  - Required: both ports return 0 in every case.
- Parameter sweep: rerun the write/read test with DATA_WIDTH=16 and ADDR_WIDTH=4 over all 16 entries.
  - Required: data matches and there are no width truncation warnings.

Source files
------------

// File: rtl/param_register_file.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, two registered read ports, bulk clear.
// Reads return one cycle after request; optional write-to-read bypass and hardwired-zero entry 0.
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re0,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic                  rd_valid0,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  rd_valid1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  re_i    [2];
  logic [ADDR_WIDTH-1:0] addr_i  [2];
  logic [DATA_WIDTH-1:0] data_q  [2];
  logic [DATA_WIDTH-1:0] data_d  [2];
  logic                  valid_q [2];
  logic                  valid_d [2];

  logic wr_ok;

  // A write only lands if clear is low and it does not target a hardwired-zero entry.
  assign wr_ok = we && !clear && !((ZERO_REG != 0) && (wr_addr == '0));

  assign re_i[0]   = re0;
  assign re_i[1]   = re1;
  assign addr_i[0] = rd_addr0;
  assign addr_i[1] = rd_addr1;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      valid_d[p] = re_i[p];
      data_d[p]  = data_q[p];
      if (re_i[p]) begin
        if ((ZERO_REG != 0) && (addr_i[p] == '0)) begin
          data_d[p] = '0;
        end else if ((BYPASS != 0) && wr_ok && (wr_addr == addr_i[p])) begin
          data_d[p] = wr_data;
        end else begin
          data_d[p] = mem_q[addr_i[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int p = 0; p < 2; p++) begin
        data_q[p]  <= '0;
        valid_q[p] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      for (int p = 0; p < 2; p++) begin
        data_q[p]  <= data_d[p];
        valid_q[p] <= valid_d[p];
      end
    end
  end

  assign rd_data0  = data_q[0];
  assign rd_valid0 = valid_q[0];
  assign rd_data1  = data_q[1];
  assign rd_valid1 = valid_q[1];

endmodule

// File: tb/tb_param_register_file.sv
// Bench: four register-file configurations driven in lockstep and checked against an array model.
module tb_param_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, we, re0, re1;
  logic [2:0]  wr_addr, rd_addr0, rd_addr1;
  logic [31:0] wr_data;
  logic [3:0]  wa4, ra0_4, ra1_4;
  logic [15:0] wd16;

  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic        v0  [3];
  logic        v1  [3];
  logic [15:0] w_rd0, w_rd1;
  logic        w_v0, w_v1;

  int checks = 0;
  int errors = 0;

  // instance 0: bypass, 1: no bypass, 2: bypass + zero register
  param_register_file #(.BYPASS(1), .ZERO_REG(0)) u_byp (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .re0(re0), .rd_addr0(rd_addr0), .rd_data0(rd0[0]), .rd_valid0(v0[0]),
    .re1(re1), .rd_addr1(rd_addr1), .rd_data1(rd1[0]), .rd_valid1(v1[0]));
  param_register_file #(.BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .re0(re0), .rd_addr0(rd_addr0), .rd_data0(rd0[1]), .rd_valid0(v0[1]),
    .re1(re1), .rd_addr1(rd_addr1), .rd_data1(rd1[1]), .rd_valid1(v1[1]));
  param_register_file #(.BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .re0(re0), .rd_addr0(rd_addr0), .rd_data0(rd0[2]), .rd_valid0(v0[2]),
    .re1(re1), .rd_addr1(rd_addr1), .rd_data1(rd1[2]), .rd_valid1(v1[2]));
  param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYPASS(1), .ZERO_REG(0)) u_wide (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wr_addr(wa4), .wr_data(wd16),
    .re0(re0), .rd_addr0(ra0_4), .rd_data0(w_rd0), .rd_valid0(w_v0),
    .re1(re1), .rd_addr1(ra1_4), .rd_data1(w_rd1), .rd_valid1(w_v1));

  // Reference model: contents and expected read registers per configuration.
  int          byp_c [3] = '{1, 0, 1};
  int          zr_c  [3] = '{0, 0, 1};
  logic [31:0] m_mem [3][8];
  logic [31:0] e_d   [3][2];
  logic        e_v   [3][2];
  logic [15:0] mw_mem [16];
  logic [15:0] ew_d  [2];
  logic        ew_v  [2];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
      for (int p = 0; p < 2; p++) begin e_d[k][p] = '0; e_v[k][p] = 1'b0; end
    end
    for (int i = 0; i < 16; i++) mw_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin ew_d[p] = '0; ew_v[p] = 1'b0; end
  endtask

  task automatic model_edge();
    logic [2:0] ra [2];
    logic [3:0] rw [2];
    logic       rq [2];
    bit         dropped;
    ra[0] = rd_addr0; ra[1] = rd_addr1;
    rw[0] = ra0_4;    rw[1] = ra1_4;
    rq[0] = re0;      rq[1] = re1;
    for (int k = 0; k < 3; k++) begin
      dropped = (zr_c[k] != 0) && (wr_addr == 3'd0);
      for (int p = 0; p < 2; p++) begin
        e_v[k][p] = rq[p];
        if (rq[p]) begin
          if (zr_c[k] != 0 && ra[p] == 3'd0) e_d[k][p] = 32'd0;
          else if (byp_c[k] != 0 && we && !clear && wr_addr == ra[p] && !dropped) e_d[k][p] = wr_data;
          else e_d[k][p] = m_mem[k][ra[p]];
        end
      end
      if (clear) for (int i = 0; i < 8; i++) m_mem[k][i] = 32'd0;
      else if (we && !dropped) m_mem[k][wr_addr] = wr_data;
    end
    for (int p = 0; p < 2; p++) begin
      ew_v[p] = rq[p];
      if (rq[p]) ew_d[p] = (we && !clear && wa4 == rw[p]) ? wd16 : mw_mem[rw[p]];
    end
    if (clear) for (int i = 0; i < 16; i++) mw_mem[i] = 16'd0;
    else if (we) mw_mem[wa4] = wd16;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic c, input logic w, input logic [2:0] wa, input logic [31:0] wd,
                        input logic r0, input logic [2:0] a0, input logic r1, input logic [2:0] a1);
    clear = c; we = w; wr_addr = wa; wr_data = wd;
    re0 = r0; rd_addr0 = a0; re1 = r1; rd_addr1 = a1;
    wa4 = {1'b0, wa}; wd16 = wd[15:0]; ra0_4 = {1'b0, a0}; ra1_4 = {1'b0, a1};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd0[k] !== 32'd0 || rd1[k] !== 32'd0 || v0[k] !== 1'b0 || v1[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init inst%0d: got %h %h %b %b want all zero", k, rd0[k], rd1[k], v0[k], v1[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 3, 1, 3);
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd0[k] !== 32'hDEADBEEF || v0[k] !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset_read inst%0d: got %h/%b want deadbeef/1", k, rd0[k], v0[k]);
      end
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd0[k] !== 32'd0 || rd1[k] !== 32'd0 || v0[k] !== 1'b0 || v1[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d: got %h %h %b %b want all zero", k, rd0[k], rd1[k], v0[k], v1[k]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd0[k] !== 32'd0 || v0[k] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_read inst%0d: got %h/%b want 0/1", k, rd0[k], v0[k]);
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 3'(i), 32'h1000_0000 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i));
      tick();
      checks++;
      if (rd0[0] !== 32'h1000_0000 + 32'(i) || rd1[0] !== 32'h1000_0007 - 32'(i) || !v0[0] || !v1[0]) begin
        errors++;
        $display("FAIL write_read addr %0d: got %h/%h want %h/%h", i, rd0[0], rd1[0],
                 32'h1000_0000 + 32'(i), 32'h1000_0007 - 32'(i));
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (rd0[k] !== e_d[k][0] || rd1[k] !== e_d[k][1] || v0[k] !== e_v[k][0] || v1[k] !== e_v[k][1]) begin
          errors++;
          $display("FAIL write_read inst%0d addr %0d: got %h/%h want %h/%h", k, i, rd0[k], rd1[k], e_d[k][0], e_d[k][1]);
        end
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (v0[0] !== 1'b0 || v1[0] !== 1'b0 || rd0[0] !== 32'h1000_0007 || rd1[0] !== 32'h1000_0000) begin
      errors++;
      $display("FAIL idle_hold: got %b/%b %h/%h want 0/0 10000007/10000000", v0[0], v1[0], rd0[0], rd1[0]);
    end
  endtask

  task automatic test_bypass();
    set_in(0, 1, 5, 32'h0000_00AA, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 5, 32'h0000_0055, 1, 5, 0, 0);
    tick();
    checks++;
    if (rd0[0] !== 32'h55 || rd0[1] !== 32'hAA || rd0[2] !== 32'h55) begin
      errors++;
      $display("FAIL bypass: got byp=%h nobyp=%h zero=%h want 55/aa/55", rd0[0], rd0[1], rd0[2]);
    end
    set_in(0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    checks++;
    if (rd0[1] !== 32'h55 || v0[1] !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_followup: got %h/%b want 55/1", rd0[1], v0[1]);
    end
  endtask

  task automatic test_clear_vs_write();
    set_in(0, 1, 2, 32'h77, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 2, 32'h1234, 0, 0, 1, 2);
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd1[k] !== 32'h77 || v1[k] !== 1'b1) begin
        errors++;
        $display("FAIL clear_same_cycle inst%0d: got %h/%b want 77/1", k, rd1[k], v1[k]);
      end
    end
    set_in(0, 0, 0, 0, 1, 5, 1, 2);
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd1[k] !== 32'd0 || rd0[k] !== 32'd0) begin
        errors++;
        $display("FAIL after_clear inst%0d: got %h/%h want 0/0", k, rd0[k], rd1[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    set_in(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0);
    tick();
    checks++;
    if (rd0[2] !== 32'd0 || rd1[2] !== 32'd0 || rd0[0] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_reg_same: got zero=%h/%h byp=%h want 0/0 ffffffff", rd0[2], rd1[2], rd0[0]);
    end
    set_in(0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    checks++;
    if (rd0[2] !== 32'd0 || rd1[2] !== 32'd0 || rd1[0] !== 32'hFFFF_FFFF || !v0[2] || !v1[2]) begin
      errors++;
      $display("FAIL zero_reg_next: got zero=%h/%h byp=%h want 0/0 ffffffff", rd0[2], rd1[2], rd1[0]);
    end
  endtask

  task automatic test_param_sweep();
    for (int j = 0; j < 16; j++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 0);
      wa4 = 4'(j); wd16 = 16'hC000 + 16'(j * 257);
      tick();
    end
    for (int j = 0; j < 16; j++) begin
      set_in(0, 0, 0, 0, 1, 0, 1, 0);
      ra0_4 = 4'(j); ra1_4 = 4'(15 - j);
      tick();
      checks++;
      if (w_rd0 !== 16'hC000 + 16'(j * 257) || w_rd1 !== 16'hC000 + 16'((15 - j) * 257) || !w_v0 || !w_v1) begin
        errors++;
        $display("FAIL sweep16 addr %0d: got %h/%h want %h/%h", j, w_rd0, w_rd1,
                 16'hC000 + 16'(j * 257), 16'hC000 + 16'((15 - j) * 257));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom), $urandom,
             1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
      wa4 = 4'($urandom); wd16 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra0_4 = wa4; else ra0_4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr1 = wr_addr;
      ra1_4 = 4'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd0[k] !== e_d[k][0] || rd1[k] !== e_d[k][1] || v0[k] !== e_v[k][0] || v1[k] !== e_v[k][1]) begin
          errors++;
          $display("FAIL random cyc %0d inst%0d: got %h/%b %h/%b want %h/%b %h/%b", n, k,
                   rd0[k], v0[k], rd1[k], v1[k], e_d[k][0], e_v[k][0], e_d[k][1], e_v[k][1]);
        end
      end
      checks++;
      if (w_rd0 !== ew_d[0] || w_rd1 !== ew_d[1] || w_v0 !== ew_v[0] || w_v1 !== ew_v[1]) begin
        errors++;
        $display("FAIL random16 cyc %0d: got %h/%b %h/%b want %h/%b %h/%b", n,
                 w_rd0, w_v0, w_rd1, w_v1, ew_d[0], ew_v[0], ew_d[1], ew_v[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_vs_write();
    test_zero_reg();
    test_param_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
